// File: rtl/ahb_lite_master_arbiter.sv
// ============================================================================
// Module   : ahb_lite_master_arbiter
// Purpose  : Round-robin arbiter sharing one pipelined AHB-Lite master port
//            between NUM_REQ single-transfer requesters. Optional macro
//            AHB_ARB_LOCK_EN adds req_lock/HMASTLOCK locked sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_lite_master_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*3-1:0]          req_size,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [ADDR_WIDTH-1:0]         HADDR,
    output logic [1:0]                    HTRANS,
    output logic                          HWRITE,
    output logic [2:0]                    HSIZE,
    output logic [2:0]                    HBURST,
    output logic [DATA_WIDTH-1:0]         HWDATA,
    input  logic [DATA_WIDTH-1:0]         HRDATA,
    input  logic                          HREADY
`ifdef AHB_ARB_LOCK_EN
    ,
    input  logic [NUM_REQ-1:0]            req_lock,
    output logic                          HMASTLOCK
`endif
);

    localparam int          IDW           = $clog2(NUM_REQ);
    localparam int          CW            = IDW + 1;
    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0]  HSIZE_RESET   = 3'b010;

    logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];
    logic [2:0]            w_size_arr  [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_size_arr[gi]  = req_size[gi*3 +: 3];
    end

    // Address-phase register A
    logic                  a_vld_q;
    logic [IDW-1:0]        a_id_q;
    logic [ADDR_WIDTH-1:0] a_addr_q;
    logic                  a_write_q;
    logic [2:0]            a_size_q;
    logic [DATA_WIDTH-1:0] a_wdata_q;
    // Data-phase register D
    logic                  d_vld_q;
    logic [IDW-1:0]        d_id_q;
    logic                  d_write_q;
    logic [DATA_WIDTH-1:0] d_wdata_q;

    logic [IDW-1:0]        last_id_q;
    logic                  w_locked;

    logic                  w_grant_any;
    logic [IDW-1:0]        w_grant_id;
    logic [CW-1:0]         w_cand;
    logic [IDW-1:0]        w_cand_id;
    logic                  w_accept;

    // Search starts one past the last winner; while locked only the owner is eligible.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        w_cand      = '0;
        w_cand_id   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_cand = {1'b0, last_id_q} + CW'(off);
            if (w_cand >= CW'(NUM_REQ)) begin
                w_cand = w_cand - CW'(NUM_REQ);
            end
            w_cand_id = w_cand[IDW-1:0];
            if (!w_grant_any && req_valid[w_cand_id] &&
                (!w_locked || (w_cand_id == last_id_q))) begin
                w_grant_any = 1'b1;
                w_grant_id  = w_cand_id;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_grant_any && HREADY && !HRESET) begin
            req_ready[w_grant_id] = 1'b1;
        end
    end

    assign w_accept = |req_ready;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_vld_q   <= 1'b0;
            a_id_q    <= '0;
            a_addr_q  <= '0;
            a_write_q <= 1'b0;
            a_size_q  <= HSIZE_RESET;
            a_wdata_q <= '0;
            d_vld_q   <= 1'b0;
            d_id_q    <= '0;
            d_write_q <= 1'b0;
            d_wdata_q <= '0;
            last_id_q <= IDW'(NUM_REQ - 1);
        end else if (HREADY) begin
            d_vld_q   <= a_vld_q;
            d_id_q    <= a_id_q;
            d_write_q <= a_write_q;
            d_wdata_q <= a_wdata_q;
            if (w_accept) begin
                a_vld_q   <= 1'b1;
                a_id_q    <= w_grant_id;
                a_addr_q  <= w_addr_arr[w_grant_id];
                a_write_q <= req_write[w_grant_id];
                a_size_q  <= w_size_arr[w_grant_id];
                a_wdata_q <= w_wdata_arr[w_grant_id];
                last_id_q <= w_grant_id;
            end else begin
                // Non-address fields hold; HTRANS=IDLE marks them as don't-care.
                a_vld_q   <= 1'b0;
            end
        end
    end

`ifdef AHB_ARB_LOCK_EN
    logic lock_q;
    logic a_lock_q;

    // The command that ends a locked sequence is itself still a locked transfer.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            lock_q   <= 1'b0;
            a_lock_q <= 1'b0;
        end else if (HREADY) begin
            if (w_accept) begin
                lock_q   <= req_lock[w_grant_id];
                a_lock_q <= req_lock[w_grant_id] | lock_q;
            end else begin
                a_lock_q <= lock_q;
            end
        end
    end

    assign w_locked  = lock_q;
    assign HMASTLOCK = a_lock_q;
`else
    assign w_locked  = 1'b0;
`endif

    assign HTRANS = a_vld_q ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR  = a_addr_q;
    assign HWRITE = a_write_q;
    assign HSIZE  = a_size_q;
    assign HBURST = 3'b000;
    assign HWDATA = d_wdata_q;

    // Reads and writes both complete with a strobe; d_write only affects rdata meaning.
    always_comb begin
        rsp_valid = '0;
        if (d_vld_q && HREADY && !HRESET) begin
            rsp_valid[d_id_q] = 1'b1;
        end
    end

    assign rsp_rdata = HRDATA;

    logic w_unused;
    assign w_unused = d_write_q;

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_master_arbiter.sv
// ============================================================================
// Module   : tb_ahb_lite_master_arbiter
// Purpose  : Table-driven directed bench for ahb_lite_master_arbiter (NUM_REQ=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_lite_master_arbiter;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] NS = 2'b10;

    logic        HCLK;
    logic        HRESET;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_addr;
    logic [1:0]  req_write;
    logic [5:0]  req_size;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
`ifdef AHB_ARB_LOCK_EN
    logic [1:0]  req_lock;
    logic        HMASTLOCK;
`endif

    ahb_lite_master_arbiter #(
        .NUM_REQ   (2),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_write(req_write),
        .req_size (req_size),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HBURST   (HBURST),
        .HWDATA   (HWDATA),
        .HRDATA   (HRDATA),
        .HREADY   (HREADY)
`ifdef AHB_ARB_LOCK_EN
        ,
        .req_lock (req_lock),
        .HMASTLOCK(HMASTLOCK)
`endif
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        rst;
        logic [1:0]  val;
        logic [1:0]  wr;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] wd0;
        logic [2:0]  sz;
        logic        hr;
        logic [31:0] hrd;
        logic [1:0]  rdy;
        logic        ca;
        logic [1:0]  ht;
        logic [31:0] ha;
        logic        hw;
        logic [2:0]  hs;
        logic        cw;
        logic [31:0] hwd;
        logic [1:0]  rv;
        logic        cr;
        logic [31:0] rd;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    int n_vec  = 0;
    int n_miss = 0;

    function automatic vec_t mk(
        input logic rst, input logic [1:0] val, input logic [1:0] wr,
        input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] wd0,
        input logic [2:0] sz, input logic hr, input logic [31:0] hrd,
        input logic [1:0] rdy, input logic ca, input logic [1:0] ht,
        input logic [31:0] ha, input logic hw, input logic [2:0] hs,
        input logic cw, input logic [31:0] hwd, input logic [1:0] rv,
        input logic cr, input logic [31:0] rd);
        vec_t v;
        v.rst = rst; v.val = val; v.wr = wr; v.a0 = a0; v.a1 = a1; v.wd0 = wd0;
        v.sz = sz; v.hr = hr; v.hrd = hrd; v.rdy = rdy; v.ca = ca; v.ht = ht;
        v.ha = ha; v.hw = hw; v.hs = hs; v.cw = cw; v.hwd = hwd; v.rv = rv;
        v.cr = cr; v.rd = rd;
        return v;
    endfunction

    task automatic cmp(input int idx, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL vec %0d %s: got %h expected %h", idx, nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        HRESET    = v.rst;
        req_valid = v.val;
        req_write = v.wr;
        req_addr  = {v.a1, v.a0};
        req_wdata = {32'hBBBB_1111, v.wd0};
        req_size  = {v.sz, v.sz};
        HREADY    = v.hr;
        HRDATA    = v.hrd;
    endtask

    task automatic check(input int idx, input vec_t v);
        n_vec++;
        cmp(idx, "req_ready", 32'(req_ready), 32'(v.rdy));
        cmp(idx, "HTRANS",    32'(HTRANS),    32'(v.ht));
        cmp(idx, "HBURST",    32'(HBURST),    32'd0);
        cmp(idx, "rsp_valid", 32'(rsp_valid), 32'(v.rv));
        if (v.ca) begin
            cmp(idx, "HADDR",  HADDR,         v.ha);
            cmp(idx, "HWRITE", 32'(HWRITE),   32'(v.hw));
            cmp(idx, "HSIZE",  32'(HSIZE),    32'(v.hs));
        end
        if (v.cw) cmp(idx, "HWDATA",    HWDATA,    v.hwd);
        if (v.cr) cmp(idx, "rsp_rdata", rsp_rdata, v.rd);
    endtask

    initial begin
        int cycles;

        //                rst val  wr   a0     a1     wd0           sz    hr hrdata        rdy  ca ht  haddr   hw hs    cw hwdata        rv   cr rdata
        // reset state
        tbl[0]  = mk(1, 2'b00, 2'b00, 32'h0,    32'h0,    32'h0,        3'b010, 1, 32'h0,        2'b00, 1, ID, 32'h0,    0, 3'b010, 1, 32'h0,        2'b00, 0, 32'h0);
        tbl[1]  = mk(0, 2'b00, 2'b00, 32'h0,    32'h0,    32'h0,        3'b010, 1, 32'h0,        2'b00, 1, ID, 32'h0,    0, 3'b010, 1, 32'h0,        2'b00, 0, 32'h0);
        // single write, zero wait states
        tbl[2]  = mk(0, 2'b01, 2'b01, 32'h100,  32'h0,    32'hDEADBEEF, 3'b010, 1, 32'h0,        2'b01, 1, ID, 32'h0,    0, 3'b010, 1, 32'h0,        2'b00, 0, 32'h0);
        tbl[3]  = mk(0, 2'b00, 2'b00, 32'h100,  32'h0,    32'hDEADBEEF, 3'b010, 1, 32'h0,        2'b00, 1, NS, 32'h100,  1, 3'b010, 1, 32'h0,        2'b00, 0, 32'h0);
        tbl[4]  = mk(0, 2'b00, 2'b00, 32'h0,    32'h0,    32'h0,        3'b010, 1, 32'h0,        2'b00, 0, ID, 32'h0,    0, 3'b010, 1, 32'hDEADBEEF, 2'b01, 0, 32'h0);
        // single read by requester 1, two data-phase wait states
        tbl[5]  = mk(0, 2'b10, 2'b00, 32'h0,    32'h200,  32'h0,        3'b010, 1, 32'h0,        2'b10, 0, ID, 32'h0,    0, 3'b010, 0, 32'h0,        2'b00, 0, 32'h0);
        tbl[6]  = mk(0, 2'b00, 2'b00, 32'h0,    32'h200,  32'h0,        3'b010, 1, 32'h0,        2'b00, 1, NS, 32'h200,  0, 3'b010, 0, 32'h0,        2'b00, 0, 32'h0);
        tbl[7]  = mk(0, 2'b00, 2'b00, 32'h0,    32'h0,    32'h0,        3'b010, 0, 32'hBAD0BAD0, 2'b00, 0, ID, 32'h0,    0, 3'b010, 0, 32'h0,        2'b00, 0, 32'h0);
        tbl[8]  = mk(0, 2'b00, 2'b00, 32'h0,    32'h0,    32'h0,        3'b010, 0, 32'hBAD0BAD0, 2'b00, 0, ID, 32'h0,    0, 3'b010, 0, 32'h0,        2'b00, 0, 32'h0);
        tbl[9]  = mk(0, 2'b00, 2'b00, 32'h0,    32'h0,    32'h0,        3'b010, 1, 32'h12345678, 2'b00, 0, ID, 32'h0,    0, 3'b010, 0, 32'h0,        2'b10, 1, 32'h12345678);
        // contention: both valid, alternating grants, no IDLE gaps
        tbl[10] = mk(0, 2'b11, 2'b01, 32'h1000, 32'h2000, 32'hAAAA0000, 3'b010, 1, 32'h0,        2'b01, 0, ID, 32'h0,    0, 3'b010, 0, 32'h0,        2'b00, 0, 32'h0);
        tbl[11] = mk(0, 2'b11, 2'b01, 32'h1000, 32'h2000, 32'hAAAA0000, 3'b010, 1, 32'h0,        2'b10, 1, NS, 32'h1000, 1, 3'b010, 0, 32'h0,        2'b00, 0, 32'h0);
        tbl[12] = mk(0, 2'b11, 2'b01, 32'h1000, 32'h2000, 32'hAAAA0000, 3'b010, 1, 32'h0,        2'b01, 1, NS, 32'h2000, 0, 3'b010, 1, 32'hAAAA0000, 2'b01, 0, 32'h0);
        tbl[13] = mk(0, 2'b11, 2'b01, 32'h1000, 32'h2000, 32'hAAAA0000, 3'b010, 1, 32'h0BB00001, 2'b10, 1, NS, 32'h1000, 1, 3'b010, 0, 32'h0,        2'b10, 1, 32'h0BB00001);
        tbl[14] = mk(0, 2'b11, 2'b01, 32'h1000, 32'h2000, 32'hAAAA0000, 3'b010, 1, 32'h0,        2'b01, 1, NS, 32'h2000, 0, 3'b010, 1, 32'hAAAA0000, 2'b01, 0, 32'h0);
        tbl[15] = mk(0, 2'b11, 2'b01, 32'h1000, 32'h2000, 32'hAAAA0000, 3'b010, 1, 32'h0BB00002, 2'b10, 1, NS, 32'h1000, 1, 3'b010, 0, 32'h0,        2'b10, 1, 32'h0BB00002);
        // arrival during a stall: nothing accepted, outputs frozen
        tbl[16] = mk(0, 2'b01, 2'b01, 32'h1000, 32'h2000, 32'hAAAA0000, 3'b010, 0, 32'h0,        2'b00, 1, NS, 32'h2000, 0, 3'b010, 1, 32'hAAAA0000, 2'b00, 0, 32'h0);
        tbl[17] = mk(0, 2'b11, 2'b01, 32'h1000, 32'h2000, 32'hAAAA0000, 3'b010, 0, 32'h0,        2'b00, 1, NS, 32'h2000, 0, 3'b010, 1, 32'hAAAA0000, 2'b00, 0, 32'h0);
        tbl[18] = mk(0, 2'b11, 2'b01, 32'h1000, 32'h2000, 32'hAAAA0000, 3'b010, 1, 32'h0,        2'b01, 1, NS, 32'h2000, 0, 3'b010, 1, 32'hAAAA0000, 2'b01, 0, 32'h0);
        tbl[19] = mk(0, 2'b10, 2'b01, 32'h1000, 32'h2000, 32'hAAAA0000, 3'b010, 1, 32'h55AA55AA, 2'b10, 1, NS, 32'h1000, 1, 3'b010, 0, 32'h0,        2'b10, 1, 32'h55AA55AA);
        // reset with a transfer in flight, then requester 0 wins first
        tbl[20] = mk(1, 2'b00, 2'b00, 32'h0,    32'h0,    32'h0,        3'b010, 1, 32'h0,        2'b00, 0, NS, 32'h0,    0, 3'b010, 0, 32'h0,        2'b00, 0, 32'h0);
        tbl[21] = mk(0, 2'b11, 2'b01, 32'h1000, 32'h2000, 32'hAAAA0000, 3'b001, 1, 32'h0,        2'b01, 1, ID, 32'h0,    0, 3'b010, 1, 32'h0,        2'b00, 0, 32'h0);
        tbl[22] = mk(0, 2'b00, 2'b00, 32'h0,    32'h0,    32'h0,        3'b001, 1, 32'h0,        2'b00, 1, NS, 32'h1000, 1, 3'b001, 0, 32'h0,        2'b00, 0, 32'h0);
        tbl[23] = mk(0, 2'b00, 2'b00, 32'h0,    32'h0,    32'h0,        3'b010, 1, 32'h0,        2'b00, 0, ID, 32'h0,    0, 3'b010, 1, 32'hAAAA0000, 2'b01, 0, 32'h0);

        HRESET    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_size  = '0;
        req_wdata = '0;
        HREADY    = 1'b1;
        HRDATA    = '0;
`ifdef AHB_ARB_LOCK_EN
        req_lock  = '0;
`endif

        for (int i = 0; i < NV; i++) begin
            @(posedge HCLK);
            #1 apply(tbl[i]);
            @(negedge HCLK);
            check(i, tbl[i]);
        end

        // Read with one address-phase wait state: accept, stalled NONSEQ, NONSEQ, response.
        @(posedge HCLK);
        #1;
        HRESET    = 1'b0;
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr  = {32'h0, 32'h300};
        req_size  = {3'b010, 3'b010};
        HREADY    = 1'b1;
        @(negedge HCLK);
        n_vec++;
        cmp(100, "seq accept req_ready", 32'(req_ready), 32'h1);

        @(posedge HCLK);
        #1;
        req_valid = 2'b00;
        HREADY    = 1'b0;
        @(negedge HCLK);
        n_vec++;
        cmp(101, "seq stall HTRANS",    32'(HTRANS),    32'(NS));
        cmp(101, "seq stall HADDR",     HADDR,          32'h300);
        cmp(101, "seq stall rsp_valid", 32'(rsp_valid), 32'h0);

        @(posedge HCLK);
        #1;
        HREADY = 1'b1;
        HRDATA = 32'hCAFEF00D;
        @(negedge HCLK);
        n_vec++;
        cmp(102, "seq addr HTRANS",    32'(HTRANS),    32'(NS));
        cmp(102, "seq addr HADDR",     HADDR,          32'h300);
        cmp(102, "seq addr rsp_valid", 32'(rsp_valid), 32'h0);

        @(posedge HCLK);
        #1;
        cycles = 0;
        while (rsp_valid !== 2'b01 && cycles < 8) begin
            @(posedge HCLK);
            #1;
            cycles++;
        end
        n_vec++;
        cmp(103, "seq rsp latency",   32'(cycles),    32'd0);
        cmp(103, "seq rsp_valid",     32'(rsp_valid), 32'h1);
        cmp(103, "seq rsp_rdata",     rsp_rdata,      32'hCAFEF00D);
        cmp(103, "seq idle HTRANS",   32'(HTRANS),    32'(ID));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
